// File: rtl/dla_hld_ram_burst_reader.sv
// dla_hld_ram_burst_reader: credit-based burst reader with latency pipe and output FIFO; DLA_HLD_RAM_BURST_READER_PERF_EN adds perf_stall_cycles
module dla_hld_ram_burst_reader #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  parameter int READ_LATENCY = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W = 16,
  localparam int ADDR = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ADDR-1:0]  cmd_address,
  input  logic [LEN_W-1:0] cmd_length,
  output logic [ADDR-1:0]  ram_address,
  output logic             ram_read_enable,
  output logic             ram_in_clock_en,
  output logic             ram_out_clock_en,
  input  logic [WIDTH-1:0] ram_readdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
`ifdef DLA_HLD_RAM_BURST_READER_PERF_EN
  , output logic [31:0]    perf_stall_cycles
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  if (FIFO_DEPTH < READ_LATENCY + 1) begin : g_bad_fifo
    $error("FIFO_DEPTH must be >= READ_LATENCY+1");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_lat
    $error("READ_LATENCY must be 1..8");
  end
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state;
  logic [ADDR-1:0] addr;
  logic [LEN_W-1:0] remaining;
  logic [CW-1:0] credits, count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic rd_last;
  logic [READ_LATENCY-1:0] pipe_v, pipe_l;
  logic [WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic fifo_last [FIFO_DEPTH];
  logic issue, push, pop;
  assign issue = state == ISSUE && credits != '0;
  assign push = pipe_v[READ_LATENCY-1];
  assign pop = out_valid && out_ready;
  assign ram_in_clock_en = 1'b1;
  assign ram_out_clock_en = 1'b1;
  assign out_valid = count != '0;
  assign out_data = fifo_data[rd_ptr];
  assign out_last = out_valid && fifo_last[rd_ptr];
  // credits already account for every word in flight or queued
  assign busy = state == ISSUE || credits != CW'(FIFO_DEPTH);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cmd_ready <= 1'b1;
      ram_read_enable <= 1'b0;
      ram_address <= '0;
      rd_last <= 1'b0;
      addr <= '0;
      remaining <= '0;
      credits <= CW'(FIFO_DEPTH);
      pipe_v <= '0;
      pipe_l <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      ram_read_enable <= issue;
      if (issue) begin
        ram_address <= addr;
        rd_last <= remaining == LEN_W'(1);
        addr <= addr == ADDR'(DEPTH - 1) ? '0 : addr + ADDR'(1);
        remaining <= remaining - LEN_W'(1);
        if (remaining == LEN_W'(1)) begin
          state <= IDLE;
          cmd_ready <= 1'b1;
        end
      end
      if (state == IDLE && cmd_valid && cmd_length != '0) begin
        addr <= cmd_address;
        remaining <= cmd_length;
        state <= ISSUE;
        cmd_ready <= 1'b0;
      end
      credits <= credits + CW'(pop) - CW'(issue);
      pipe_v <= READ_LATENCY'({pipe_v, ram_read_enable});
      pipe_l <= READ_LATENCY'({pipe_l, rd_last});
      if (push) wr_ptr <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= ram_readdata;
      fifo_last[wr_ptr] <= pipe_l[READ_LATENCY-1];
    end
  end
`ifdef DLA_HLD_RAM_BURST_READER_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) perf_stall_cycles <= '0;
    else if (state == ISSUE && credits == '0 && perf_stall_cycles != '1) perf_stall_cycles <= perf_stall_cycles + 32'd1;
  end
`endif
endmodule
